rng_scheduler: RTL and testbench
================================

Name: rng_scheduler

Overview:
- Shares the single masking-randomness generator (RNG) between NUM_REQ consumers, e.g. masked S-box lanes and key-schedule blocks.
- Round-robin arbitrates requests, pulses the RNG enable, captures one fresh bundle and hands it to exactly one winner over a valid/ready handshake.
- Guarantees no bundle is ever delivered twice, and scrubs its holding register after every use.
- Sits between the RNG and the masked datapath consumers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- RAND_W, 3456, bundle width; equals the RNG full-output width.
- TIMEOUT, 16, cycles allowed from enable pulse to RNG valid (must be ≥ 2).
- CNT_W, 16, width of the delivered-bundle counter.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- req_i  in  NUM_REQ  per-requester request level.
- rand_ready_i  in  NUM_REQ  per-requester accept.
- rand_valid_o  out  NUM_REQ  one-hot bundle valid.
- rand_o  out  RAND_W  bundle data, shared bus.
- gnt_id_o  out  $clog2(NUM_REQ)  current grant index.
- rng_enable_o  out  1  one-cycle pulse to the RNG enable.
- rng_valid_i  in  1  RNG output valid.
- rng_data_i  in  RAND_W  RNG full bundle.
- busy_o  out  1  state != IDLE.
- timeout_o  out  1  sticky RNG-timeout error.
- clr_err_i  in  1  clears timeout_o.
- bundle_cnt_o  out  CNT_W  delivered bundles, wraps.

Behaviour:
- Reset: all outputs 0, state IDLE, RR pointer 0, buffer all-zero, counter 0.
- States: IDLE, ISSUE, WAIT, DELIVER.
- IDLE
  - If any req_i bit is set: latch the RR winner into gnt_id_o and go to ISSUE.
  - Winner is the first set bit at or after the pointer, searching upward with wrap.
- ISSUE
  - rng_enable_o = 1 for exactly this cycle.
  - Zero the timeout counter and go to WAIT.
- WAIT
  - On rng_valid_i: capture rng_data_i into the buffer and go to DELIVER.
  - Otherwise increment the counter. When counter == TIMEOUT-1: set timeout_o, clear the grant, go to IDLE. The RR pointer does not advance, so the same requester re-wins if it is still requesting.
- DELIVER
  - rand_valid_o[gnt] = 1, rand_o = buffer.
  - If rand_ready_i[gnt]: zero the buffer, advance the pointer to gnt+1 (mod NUM_REQ), increment bundle_cnt_o, go to IDLE.
  - If req_i[gnt] drops before ready: zero the buffer, discard the bundle without reissuing it, advance the pointer, do not count it, go to IDLE.
  - If ready and the req drop happen in the same cycle, the bundle is delivered.
- Latency, best case: req sampled at edge k → rng_enable_o high in cycle k+1 → RNG valid in k+2 → rand_valid_o in k+3. Minimum 4 cycles between successive grants.
- rand_o is all-zero whenever no rand_valid_o bit is set. Stale randomness is never visible.
- rng_valid_i outside WAIT is ignored, and that data is never captured.
- Requester stability: req_i changes on non-granted bits never affect an in-flight transaction.
- clr_err_i clears timeout_o. If a new timeout occurs in the same cycle, set wins.
- Freshness invariant: the number of rng_enable_o pulses is always ≥ delivered + discarded + timed-out transactions, and each pulse backs at most one delivery.
- Asserting resetn low mid-transaction aborts immediately. Any pending RNG valid after reset release is ignored because the state is IDLE.

Decomposition:
- Shared package rng_pkg:
  - RAND_W.
  - Slice constants: M0 [255:0], M1 [511:256], RW [943:512], RB full. These let consumers extract fields from rand_o.
  - Scheduler state enum.
- Sub-module rr_arbiter (NUM_REQ): combinational pick from req + pointer, returning a grant index and an any-request flag. The pointer register stays in rng_scheduler.

Test Plan:
- Single request: req_i=0001, ready held high, RNG valid 1 cycle after enable → rng_enable_o pulses once at k+1, rand_valid_o=0001 at k+3 with rand_o = RNG data, bundle_cnt_o=1, buffer reads 0 afterwards.
- Fairness: req_i=1111 held, ready always high, 8 transactions → gnt_id_o sequence 0,1,2,3,0,1,2,3 with exactly 8 enable pulses and 8 distinct bundles.
- Backpressure: grant req 2, hold ready low 5 cycles → rand_valid_o=0100 and rand_o stable for all 5 cycles, no extra enable pulses, delivery on the ready cycle.
- Timeout: RNG never asserts valid → timeout_o set 16 cycles after the enable pulse, state returns to IDLE, re-issue goes to the same requester, clr_err_i clears the flag.
- Abandon: requester 1 drops req during DELIVER → rand_valid_o falls, bundle_cnt_o unchanged, next grant goes to requester 2, new enable pulse issued with no old data reused.
- Reset mid-WAIT: resetn low, then a late rng_valid_i after release → all outputs 0 and no capture; a fresh request then completes normally.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared constants and types for the masking-randomness scheduler and its consumers.
package rng_pkg;
    localparam int RAND_W = 3456;

    // Field positions inside a delivered bundle
    localparam int M0_LSB = 0;
    localparam int M0_MSB = 255;
    localparam int M1_LSB = 256;
    localparam int M1_MSB = 511;
    localparam int RW_LSB = 512;
    localparam int RW_MSB = 943;
    localparam int RB_LSB = 0;
    localparam int RB_MSB = RAND_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or above the pointer, searching upward with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is used.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [$clog2(NUM_REQ)-1:0] gnt_o,
    output logic                       any_o
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] w_rot;
    logic [IDX_W-1:0]   w_off;
    logic [IDX_W:0]     w_sum;

    // Rotate so bit 0 is the requester at the pointer
    assign w_rot = NUM_REQ'({req_i, req_i} >> ptr_i);

    always_comb begin
        w_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
            end
        end
    end

    assign w_sum = {1'b0, ptr_i} + {1'b0, w_off};
    assign gnt_o = (w_sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ))
                                                  : w_sum[IDX_W-1:0];
    assign any_o = |req_i;
endmodule

// File: rtl/rng_scheduler.sv
// Shares one RNG between NUM_REQ consumers; each captured bundle goes to exactly one winner.
// Latency: req sampled at edge k -> rng enable in cycle k+1 -> bundle valid in cycle k+3 at best.
// Backpressure: bundle held on rand_o until accepted or the winner drops its request.
module rng_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int RAND_W  = rng_pkg::RAND_W,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ-1:0]         rand_ready_i,
    output logic [NUM_REQ-1:0]         rand_valid_o,
    output logic [RAND_W-1:0]          rand_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id_o,
    output logic                       rng_enable_o,
    input  logic                       rng_valid_i,
    input  logic [RAND_W-1:0]          rng_data_i,
    output logic                       busy_o,
    output logic                       timeout_o,
    input  logic                       clr_err_i,
    output logic [CNT_W-1:0]           bundle_cnt_o
);
    import rng_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TW    = $clog2(TIMEOUT);

    sched_state_t      r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_gnt, w_gnt_nxt;
    logic [IDX_W-1:0]  r_ptr, w_ptr_nxt;
    logic [TW-1:0]     r_tcnt, w_tcnt_nxt;
    logic [RAND_W-1:0] r_buf, w_buf_nxt;
    logic [CNT_W-1:0]  r_bcnt, w_bcnt_nxt;
    logic              r_timeout;
    logic              w_to_set;
    logic [IDX_W-1:0]  w_win;
    logic              w_any;
    logic [TW-1:0]     w_tcnt_inc;
    logic [IDX_W-1:0]  w_ptr_inc;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i (req_i),
        .ptr_i (r_ptr),
        .gnt_o (w_win),
        .any_o (w_any)
    );

    assign w_tcnt_inc = r_tcnt + 1'b1;
    assign w_ptr_inc  = (r_gnt == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_ptr_nxt    = r_ptr;
        w_tcnt_nxt   = r_tcnt;
        w_buf_nxt    = r_buf;
        w_bcnt_nxt   = r_bcnt;
        w_to_set     = 1'b0;
        rng_enable_o = 1'b0;
        rand_valid_o = '0;
        rand_o       = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_gnt_nxt   = w_win;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rng_enable_o = 1'b1;
                w_tcnt_nxt   = '0;
                w_state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                if (rng_valid_i) begin
                    w_buf_nxt   = rng_data_i;
                    w_state_nxt = ST_DELIVER;
                end else if (w_tcnt_inc == TW'(TIMEOUT - 1)) begin
                    // Pointer stays put so the same requester re-wins
                    w_to_set    = 1'b1;
                    w_gnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tcnt_nxt = w_tcnt_inc;
                end
            end
            ST_DELIVER: begin
                rand_valid_o[r_gnt] = 1'b1;
                rand_o              = r_buf;
                if (rand_ready_i[r_gnt] || !req_i[r_gnt]) begin
                    w_buf_nxt   = '0;
                    w_ptr_nxt   = w_ptr_inc;
                    w_state_nxt = ST_IDLE;
                    if (rand_ready_i[r_gnt]) begin
                        w_bcnt_nxt = r_bcnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_ptr     <= '0;
            r_tcnt    <= '0;
            r_buf     <= '0;
            r_bcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_buf   <= w_buf_nxt;
            r_bcnt  <= w_bcnt_nxt;
            if (w_to_set) begin
                r_timeout <= 1'b1;
            end else if (clr_err_i) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign gnt_id_o     = r_gnt;
    assign busy_o       = (r_state != ST_IDLE);
    assign timeout_o    = r_timeout;
    assign bundle_cnt_o = r_bcnt;
endmodule

// File: tb/tb_rng_scheduler.sv
// Bench for rng_scheduler: transaction-level reference model, per-cycle compare, directed plus random stimulus.
module tb_rng_scheduler;
    import rng_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 16;
    localparam int CW  = 16;
    localparam int IW  = 2;

    logic              clk = 1'b0;
    logic              resetn;
    logic [N-1:0]      req_i, rand_ready_i, rand_valid_o;
    logic [RAND_W-1:0] rand_o, rng_data_i;
    logic [IW-1:0]     gnt_id_o;
    logic              rng_enable_o, rng_valid_i, busy_o, timeout_o, clr_err_i;
    logic [CW-1:0]     bundle_cnt_o;

    rng_scheduler #(.NUM_REQ(N), .RAND_W(RAND_W), .TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_i        (req_i),
        .rand_ready_i (rand_ready_i),
        .rand_valid_o (rand_valid_o),
        .rand_o       (rand_o),
        .gnt_id_o     (gnt_id_o),
        .rng_enable_o (rng_enable_o),
        .rng_valid_i  (rng_valid_i),
        .rng_data_i   (rng_data_i),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o),
        .clr_err_i    (clr_err_i),
        .bundle_cnt_o (bundle_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Reference model: owner of the RNG (-1 = nobody), whether its enable is due,
    // how long it has waited, and the bundle it currently holds.
    int                m_ptr, m_gnt, m_gid, m_wait, m_cnt;
    bit                m_issue, m_have, m_to;
    logic [RAND_W-1:0] m_data;
    int                n_deliv = 0, n_disc = 0, n_tmo = 0, n_pulse = 0;

    logic [RAND_W-1:0] obs_data[$];
    int                obs_gnt[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_wide(input string nm, input logic [RAND_W-1:0] act, input logic [RAND_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got low64 %h expected low64 %h (cycle %0d)", nm, act[63:0], exp[63:0], cyc);
        end
    endtask

    function automatic logic [RAND_W-1:0] bundle();
        logic [RAND_W-1:0] b;
        for (int i = 0; i < RAND_W / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic void model_reset();
        m_ptr = 0; m_gnt = -1; m_gid = 0; m_wait = 0; m_cnt = 0;
        m_issue = 0; m_have = 0; m_to = 0; m_data = '0;
    endfunction

    function automatic void model_release();
        m_ptr  = (m_gnt + 1) % N;
        m_gnt  = -1;
        m_have = 0;
        m_data = '0;
    endfunction

    function automatic void model_step();
        bit            tmo_evt = 0;
        logic [IW-1:0] w;
        if (m_gnt < 0) begin
            for (int i = 0; i < N; i++) begin
                w = IW'((m_ptr + i) % N);
                if (req_i[w] && m_gnt < 0) m_gnt = int'(w);
            end
            if (m_gnt >= 0) begin
                m_gid   = m_gnt;
                m_issue = 1;
            end
        end else if (m_issue) begin
            m_issue = 0;
            m_wait  = 0;
        end else if (!m_have) begin
            if (rng_valid_i) begin
                m_have = 1;
                m_data = rng_data_i;
            end else begin
                m_wait++;
                if (m_wait == TMO - 1) begin
                    tmo_evt = 1; n_tmo++;
                    m_gnt = -1; m_gid = 0;
                end
            end
        end else begin
            w = IW'(m_gnt);
            if (rand_ready_i[w]) begin
                m_cnt++; n_deliv++;
                model_release();
            end else if (!req_i[w]) begin
                n_disc++;
                model_release();
            end
        end
        m_to = tmo_evt ? 1'b1 : (clr_err_i ? 1'b0 : m_to);
    endfunction

    // Compare process: every negedge the DUT outputs must equal the model
    always @(negedge clk) begin
        logic [N-1:0]      ev;
        logic [RAND_W-1:0] er;
        if (chk_en) begin
            ev = m_have ? (N'(1) << m_gnt) : '0;
            er = m_have ? m_data : '0;
            chk("busy", 64'(busy_o), 64'(m_gnt >= 0));
            chk("enable", 64'(rng_enable_o), 64'(m_issue));
            chk("valid", 64'(rand_valid_o), 64'(ev));
            chk("gnt_id", 64'(gnt_id_o), 64'(m_gid));
            chk("timeout", 64'(timeout_o), 64'(m_to));
            chk("bundle_cnt", 64'(bundle_cnt_o), 64'(m_cnt % 65536));
            chk_wide("rand_o", rand_o, er);
            if (rng_enable_o) n_pulse++;
        end
    end

    task automatic tick();
        if (|(rand_valid_o & rand_ready_i)) begin
            obs_data.push_back(rand_o);
            obs_gnt.push_back(int'(gnt_id_o));
        end
        @(posedge clk);
        cyc++;
        if (!resetn) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        resetn = 1'b0;
        model_reset();
        req_i = '0; rand_ready_i = '0; rng_valid_i = 1'b0; clr_err_i = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic wait_en(input string nm);
        int g = 0;
        while (!rng_enable_o && g < 30) begin tick(); g++; end
        chk(nm, 64'(rng_enable_o), 64'd1);
    endtask

    task automatic wait_valid(input string nm);
        int g = 0;
        while (rand_valid_o == '0 && g < 30) begin tick(); g++; end
        chk(nm, 64'(rand_valid_o != '0), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RAND_W-1:0] pat, zero;
        int c0, en_c, v_c, p0, dup, g, e, d0;
        zero = '0;
        resetn = 1'b0; req_i = '0; rand_ready_i = '0; rng_valid_i = 1'b0;
        rng_data_i = '0; clr_err_i = 1'b0;
        model_reset();
        chk_en = 1'b1;
        @(negedge clk);
        tick(); tick();
        resetn = 1'b1;
        chk("rst_cnt", 64'(bundle_cnt_o), 64'd0);
        chk("rst_valid", 64'(rand_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);

        // Single request, RNG answers on the first WAIT cycle
        pat = bundle();
        rng_data_i = pat; rng_valid_i = 1'b1; rand_ready_i = '1; req_i = 4'b0001;
        c0 = cyc; en_c = -1; v_c = -1; p0 = n_pulse;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rng_enable_o && en_c < 0) en_c = cyc - c0;
            if (rand_valid_o != '0 && v_c < 0) begin
                v_c = cyc - c0;
                chk("single_valid", 64'(rand_valid_o), 64'h1);
                chk_wide("single_data", rand_o, pat);
                req_i = '0;
            end
        end
        chk("single_en_lat", 64'(en_c), 64'd1);
        chk("single_valid_lat", 64'(v_c), 64'd3);
        chk("single_pulses", 64'(n_pulse - p0), 64'd1);
        chk("single_cnt", 64'(bundle_cnt_o), 64'd1);
        chk_wide("single_scrub", rand_o, zero);

        // Fairness: all four requesting, always ready
        do_reset();
        obs_data.delete(); obs_gnt.delete();
        req_i = '1; rand_ready_i = '1; rng_valid_i = 1'b1; p0 = n_pulse; g = 0;
        while (obs_data.size() < 8 && g < 100) begin
            rng_data_i = bundle();
            tick(); g++;
        end
        req_i = '0;
        chk("fair_count", 64'(obs_data.size()), 64'd8);
        chk("fair_pulses", 64'(n_pulse - p0), 64'd8);
        dup = 0;
        for (int i = 0; i < obs_data.size(); i++) begin
            if (i < 8) chk("fair_gnt", 64'(obs_gnt[i]), 64'(i % 4));
            if (obs_data[i] == '0) dup++;
            for (int j = i + 1; j < obs_data.size(); j++)
                if (obs_data[i] == obs_data[j]) dup++;
        end
        chk("fair_distinct", 64'(dup), 64'd0);

        // Backpressure on requester 2
        pat = bundle();
        rng_data_i = pat; rand_ready_i = '0; req_i = 4'b0100;
        wait_valid("bp_wait");
        p0 = n_pulse;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 64'(rand_valid_o), 64'h4);
            chk_wide("bp_hold", rand_o, pat);
            if (k < 4) begin rng_data_i = bundle(); tick(); end
        end
        chk("bp_pulses", 64'(n_pulse - p0), 64'd0);
        rand_ready_i = 4'b0100;
        tick();
        chk("bp_cnt", 64'(bundle_cnt_o), 64'd9);
        chk("bp_done", 64'(rand_valid_o), 64'd0);
        req_i = '0; rand_ready_i = '0;

        // Timeout: RNG silent; requester 1 must re-win afterwards
        rng_valid_i = 1'b0; req_i = 4'b0010;
        wait_en("tmo_en");
        e = cyc; g = 0;
        while (!timeout_o && g < 40) begin tick(); g++; end
        chk("tmo_lat", 64'(cyc - e), 64'd16);
        chk("tmo_idle", 64'(busy_o), 64'd0);
        tick();
        wait_en("tmo_reissue");
        chk("tmo_regrant", 64'(gnt_id_o), 64'd1);
        chk("tmo_sticky", 64'(timeout_o), 64'd1);
        rng_valid_i = 1'b1; rand_ready_i = '1; req_i = '0;
        tick(); tick(); tick();
        chk("tmo_cnt", 64'(bundle_cnt_o), 64'd10);
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        chk("tmo_clr", 64'(timeout_o), 64'd0);

        // Abandon: requester 1 drops during DELIVER
        do_reset();
        pat = bundle();
        rng_data_i = pat; rng_valid_i = 1'b1; req_i = 4'b0010;
        wait_valid("ab_wait");
        chk("ab_valid1", 64'(rand_valid_o), 64'h2);
        req_i = 4'b0100;
        rng_data_i = bundle();
        tick();
        chk("ab_drop", 64'(rand_valid_o), 64'd0);
        chk("ab_cnt", 64'(bundle_cnt_o), 64'd0);
        wait_en("ab_en");
        chk("ab_gnt", 64'(gnt_id_o), 64'd2);
        wait_valid("ab_wait2");
        chk("ab_valid2", 64'(rand_valid_o), 64'h4);
        chk("ab_fresh", 64'(rand_o == pat), 64'd0);
        rand_ready_i = 4'b0100;
        tick();
        chk("ab_cnt2", 64'(bundle_cnt_o), 64'd1);
        req_i = '0; rand_ready_i = '0;

        // Reset mid-WAIT, then a late RNG valid that must be ignored
        rng_valid_i = 1'b0; req_i = 4'b0001; rand_ready_i = '1;
        wait_en("rw_en");
        tick(); tick();
        do_reset();
        rng_valid_i = 1'b1; rng_data_i = bundle();
        tick(); tick(); tick();
        chk("rw_busy", 64'(busy_o), 64'd0);
        chk("rw_valid", 64'(rand_valid_o), 64'd0);
        chk("rw_cnt", 64'(bundle_cnt_o), 64'd0);
        chk_wide("rw_data", rand_o, zero);
        req_i = 4'b0001; rand_ready_i = '1;
        wait_valid("rw_fresh");
        req_i = '0;
        tick();
        chk("rw_cnt2", 64'(bundle_cnt_o), 64'd1);

        // Randomized traffic, the compare process checks every cycle
        d0 = n_deliv;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 5) == 0) req_i = N'($urandom_range(0, 15));
            rand_ready_i = N'($urandom_range(0, 15));
            rng_valid_i  = ((k / 500) % 2 == 1) ? ($urandom_range(0, 29) == 0)
                                                : ($urandom_range(0, 9) < 3);
            rng_data_i   = bundle();
            clr_err_i    = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 999) == 0) do_reset();
            else tick();
        end
        chk("rand_activity", 64'(n_deliv - d0 > 20), 64'd1);
        chk("fresh_inv", 64'(n_pulse >= n_deliv + n_disc + n_tmo), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
